// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - op codes, FSM encodings and sizing helpers for the MALU mul/div pipe
//
// Purpose: shared definitions for xc_malu_mdr_pipe and xc_malu_mdr_step.
// Ports:   none (package).

package xc_malu_pkg;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_CLMUL  = 4'd8;
    localparam logic [3:0] OP_CLMULH = 4'd9;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_PREP = 5'b00010,
        ST_ITER = 5'b00100,
        ST_FIX  = 5'b01000,
        ST_DONE = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        MODE_MUL   = 2'd0,
        MODE_CLMUL = 2'd1,
        MODE_DIV   = 2'd2
    } mode_t;

    // Width of the iteration counter: must hold the value XLEN/BPC itself.
    function automatic int cnt_width(input int xlen, input int bpc);
        return $clog2(xlen / bpc) + 1;
    endfunction

endpackage

// File: rtl/xc_malu_mdr_pipe_if.sv
// rtl/xc_malu_mdr_pipe_if.sv - request/response handshake bundle of the MALU mul/div pipe
//
// Purpose: groups the request (in_*) and response (out_*) channels.
// Ports:   master = requester/consumer side, slave = the execute unit.

interface xc_malu_mdr_pipe_if #(
    parameter int XLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_op;
    logic [XLEN-1:0]     in_rs1;
    logic [XLEN-1:0]     in_rs2;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [2*XLEN-1:0]   out_wide;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_result, out_wide
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_result, out_wide
    );
endinterface

// File: rtl/xc_malu_mdr_step.sv
// rtl/xc_malu_mdr_step.sv - combinational single-iteration mul/clmul/div datapath
//
// Purpose: retires BPC bits of a shift-add multiply, shift-xor carry-less
//          multiply or restoring divide per call.
// Ports:   mode    - datapath selection
//          opnd    - multiplicand (mul/clmul) or divisor magnitude (div)
//          acc_in  - {hi, lo}: {partial product, multiplier} or {rem, quot/dividend}
//          acc_out - accumulator after BPC steps

module xc_malu_mdr_step
    import xc_malu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  mode_t               mode,
    input  logic [XLEN-1:0]     opnd,
    input  logic [2*XLEN-1:0]   acc_in,
    output logic [2*XLEN-1:0]   acc_out
);

    always_comb begin : step
        logic [2*XLEN-1:0] t;
        logic [XLEN:0]     sum;
        logic [XLEN-1:0]   hi_x;
        logic [XLEN:0]     sh;
        logic              ge;
        logic [XLEN-1:0]   diff;
        t    = acc_in;
        sum  = '0;
        hi_x = '0;
        sh   = '0;
        ge   = 1'b0;
        diff = '0;
        for (int i = 0; i < BPC; i++) begin
            case (mode)
                MODE_MUL: begin
                    // Add multiplicand when the multiplier LSB is set, then shift
                    // the whole {carry, hi, lo} right by one.
                    sum = {1'b0, t[2*XLEN-1:XLEN]} + (t[0] ? {1'b0, opnd} : '0);
                    t   = {sum, t[XLEN-1:1]};
                end
                MODE_CLMUL: begin
                    hi_x = t[2*XLEN-1:XLEN] ^ (t[0] ? opnd : '0);
                    t    = {1'b0, hi_x, t[XLEN-1:1]};
                end
                MODE_DIV: begin
                    // Shift next dividend bit into the remainder; subtract if it fits.
                    // The difference is taken mod 2^XLEN: it is only used when it is
                    // smaller than the divisor, so the dropped bit is always zero.
                    sh   = {t[2*XLEN-1:XLEN], t[XLEN-1]};
                    ge   = (sh >= {1'b0, opnd});
                    diff = sh[XLEN-1:0] - opnd;
                    t    = {(ge ? diff : sh[XLEN-1:0]), t[XLEN-2:0], ge};
                end
                default: ;
            endcase
        end
        acc_out = t;
    end

endmodule

// File: rtl/xc_malu_mdr_pipe.sv
// rtl/xc_malu_mdr_pipe.sv - multi-cycle multiply/divide/carry-less-multiply execute unit
//
// Purpose: IDLE -> PREP -> ITER -> FIX -> DONE sequencer around xc_malu_mdr_step,
//          with sign fix-up, early-out special cases and valid/ready on both sides.
// Ports:   clock - rising-edge clock
//          reset - asynchronous active-high reset
//          flush - synchronous abort of any in-flight op
//          busy  - high in any state but IDLE
//          bus   - request/response handshake (slave side)

module xc_malu_mdr_pipe
    import xc_malu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BPC       = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    output logic                busy,
    xc_malu_mdr_pipe_if.slave   bus
);

    localparam int            NSTEP    = XLEN / BPC;
    localparam int            CW       = cnt_width(XLEN, BPC);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NSTEP);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_q, state_d;
    logic [3:0]         op_q;
    logic [XLEN-1:0]    rs1_q, rs2_q, opnd_q;
    logic [2*XLEN-1:0]  acc_q, acc_step, fixed;
    logic [CW-1:0]      cnt_q;
    mode_t              mode_q;
    logic               neg_prod_q, neg_quot_q, neg_rem_q, sel_hi_q;
    logic [XLEN-1:0]    result_q;
    logic [2*XLEN-1:0]  wide_q;

    // Op decode, evaluated in PREP from the captured op.
    logic is_mul, is_clmul, is_div, sgn_a_op, sgn_b_op, sel_hi;

    always_comb begin
        is_mul   = 1'b0;
        is_clmul = 1'b0;
        is_div   = 1'b0;
        sgn_a_op = 1'b0;
        sgn_b_op = 1'b0;
        sel_hi   = 1'b0;
        case (op_q)
            OP_MUL:    is_mul = 1'b1;
            OP_MULH:   begin is_mul = 1'b1; sgn_a_op = 1'b1; sgn_b_op = 1'b1; sel_hi = 1'b1; end
            OP_MULHSU: begin is_mul = 1'b1; sgn_a_op = 1'b1; sel_hi = 1'b1; end
            OP_MULHU:  begin is_mul = 1'b1; sel_hi = 1'b1; end
            OP_DIV:    begin is_div = 1'b1; sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
            OP_DIVU:   is_div = 1'b1;
            OP_REM:    begin is_div = 1'b1; sgn_a_op = 1'b1; sgn_b_op = 1'b1; sel_hi = 1'b1; end
            OP_REMU:   begin is_div = 1'b1; sel_hi = 1'b1; end
            OP_CLMUL:  is_clmul = 1'b1;
            OP_CLMULH: begin is_clmul = 1'b1; sel_hi = 1'b1; end
            default: ;
        endcase
    end

    logic            neg_a, neg_b, div0, ovf, zmul, undef_op, early;
    logic [XLEN-1:0] mag_a, mag_b;

    assign neg_a    = sgn_a_op & rs1_q[XLEN-1];
    assign neg_b    = sgn_b_op & rs2_q[XLEN-1];
    assign mag_a    = neg_a ? -rs1_q : rs1_q;
    assign mag_b    = neg_b ? -rs2_q : rs2_q;
    assign div0     = is_div && (rs2_q == '0);
    // sgn_b_op restricts this to the signed DIV/REM pair.
    assign ovf      = is_div && sgn_b_op && (rs1_q == INT_MIN) && (&rs2_q);
    assign zmul     = (is_mul || is_clmul) && ((rs1_q == '0) || (rs2_q == '0));
    assign undef_op = !(is_mul || is_clmul || is_div);
    // Special cases skip ITER and go through FIX with the final value already in acc.
    assign early    = undef_op || ((EARLY_OUT != 0) && (div0 || ovf || zmul));

    xc_malu_mdr_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .mode    (mode_q),
        .opnd    (opnd_q),
        .acc_in  (acc_q),
        .acc_out (acc_step)
    );

    // Sign fix-up: products negate as a whole; quotient and remainder separately.
    logic [XLEN-1:0] acc_hi, acc_lo;
    assign acc_hi = acc_q[2*XLEN-1:XLEN];
    assign acc_lo = acc_q[XLEN-1:0];

    always_comb begin
        if (neg_prod_q) begin
            fixed = -acc_q;
        end else begin
            fixed = {(neg_rem_q ? -acc_hi : acc_hi), (neg_quot_q ? -acc_lo : acc_lo)};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_PREP;
            ST_PREP: state_d = early ? ST_FIX : ST_ITER;
            ST_ITER: if (cnt_q == CW'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_MUL;
            neg_prod_q <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            sel_hi_q   <= 1'b0;
            result_q   <= '0;
            wide_q     <= '0;
        end else begin
            state_q <= state_d;
            if (!flush) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.in_valid) begin
                            op_q  <= bus.in_op;
                            rs1_q <= bus.in_rs1;
                            rs2_q <= bus.in_rs2;
                        end
                    end
                    ST_PREP: begin
                        cnt_q    <= CNT_LOAD;
                        sel_hi_q <= sel_hi;
                        if (early) begin
                            mode_q     <= MODE_MUL;
                            neg_prod_q <= 1'b0;
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                            if (div0)     acc_q <= {rs1_q, {XLEN{1'b1}}};
                            else if (ovf) acc_q <= {{XLEN{1'b0}}, rs1_q};
                            else          acc_q <= '0;
                        end else begin
                            mode_q     <= is_div ? MODE_DIV : (is_clmul ? MODE_CLMUL : MODE_MUL);
                            opnd_q     <= is_div ? mag_b : mag_a;
                            acc_q      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            neg_prod_q <= is_mul && (neg_a ^ neg_b);
                            // Divide-by-zero quotient is all-ones regardless of signs.
                            neg_quot_q <= is_div && (neg_a ^ neg_b) && !div0;
                            neg_rem_q  <= is_div && neg_a;
                        end
                    end
                    ST_ITER: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q - CW'(1);
                    end
                    ST_FIX: begin
                        wide_q   <= fixed;
                        result_q <= sel_hi_q ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_wide   = wide_q;

endmodule

// File: tb/tb_xc_malu_mdr_pipe.sv
// tb/tb_xc_malu_mdr_pipe.sv - self-checking bench for xc_malu_mdr_pipe (BPC=1 early-out, BPC=4 no early-out)

module tb_xc_malu_mdr_pipe;
    import xc_malu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush1 = 1'b0;
    logic flush4 = 1'b0;
    logic busy1, busy4;

    always #5 clock = ~clock;

    xc_malu_mdr_pipe_if #(.XLEN(32)) if1 ();
    xc_malu_mdr_pipe_if #(.XLEN(32)) if4 ();

    xc_malu_mdr_pipe #(.XLEN(32), .BPC(1), .EARLY_OUT(1)) u_dut1 (
        .clock (clock), .reset (reset), .flush (flush1), .busy (busy1), .bus (if1)
    );
    xc_malu_mdr_pipe #(.XLEN(32), .BPC(4), .EARLY_OUT(0)) u_dut4 (
        .clock (clock), .reset (reset), .flush (flush4), .busy (busy4), .bus (if4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_res_q[$];
    logic [63:0] exp_wide_q[$];
    int          exp_lat_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic        ov(input int u);  return (u == 0) ? if1.out_valid  : if4.out_valid;  endfunction
    function automatic logic        rdy(input int u); return (u == 0) ? if1.in_ready   : if4.in_ready;   endfunction
    function automatic logic        bsy(input int u); return (u == 0) ? busy1          : busy4;          endfunction
    function automatic logic [31:0] res(input int u); return (u == 0) ? if1.out_result : if4.out_result; endfunction
    function automatic logic [63:0] wid(input int u); return (u == 0) ? if1.out_wide   : if4.out_wide;   endfunction

    task automatic drive(input int u, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (u == 0) begin
            if1.in_valid = v; if1.in_op = op; if1.in_rs1 = a; if1.in_rs2 = b;
        end else begin
            if4.in_valid = v; if4.in_op = op; if4.in_rs1 = a; if4.in_rs2 = b;
        end
    endtask

    task automatic set_ready(input int u, input logic r);
        if (u == 0) if1.out_ready = r;
        else        if4.out_ready = r;
    endtask

    // Reference: full-width {hi,lo} product, or {rem,quot} for divides.
    function automatic logic [63:0] ref_wide(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] as_, au, bs, bu, p;
        logic [31:0] q, r;
        as_ = {{32{a[31]}}, a};
        au  = {32'b0, a};
        bs  = {{32{b[31]}}, b};
        bu  = {32'b0, b};
        p   = '0;
        q   = '0;
        r   = '0;
        case (op)
            OP_MUL, OP_MULHU: p = au * bu;
            OP_MULH:          p = as_ * bs;
            OP_MULHSU:        p = as_ * bu;
            OP_DIV, OP_REM: begin
                if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 32'd0; end
                else begin q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b)); end
                p = {r, q};
            end
            OP_DIVU, OP_REMU: begin
                if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
                else begin q = a / b; r = a % b; end
                p = {r, q};
            end
            OP_CLMUL, OP_CLMULH: begin
                for (int i = 0; i < 32; i++) if (b[i]) p = p ^ (au << i);
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w;
        w = ref_wide(op, a, b);
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU, OP_CLMULH: return w[63:32];
            default: return w[31:0];
        endcase
    endfunction

    function automatic int ref_lat(input int u, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_div, special;
        if (op > OP_CLMULH) return 2;
        is_div  = (op >= OP_DIV) && (op <= OP_REMU);
        special = (is_div && b == 32'd0)
               || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               || (!is_div && (a == 32'd0 || b == 32'd0));
        if (u == 0) return special ? 2 : 34;
        return 10;
    endfunction

    task automatic run_op(input int u, input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        int          edges;
        logic [31:0] e_res;
        logic [63:0] e_wide;
        int          e_lat;
        exp_res_q.push_back(ref_res(op, a, b));
        exp_wide_q.push_back(ref_wide(op, a, b));
        exp_lat_q.push_back(ref_lat(u, op, a, b));
        check({tag, "_in_ready"}, 64'(rdy(u)), 64'd1);
        drive(u, 1'b1, op, a, b);
        @(posedge clock);
        @(negedge clock);
        drive(u, 1'b0, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        edges = 0;
        while (!ov(u) && edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        e_res  = exp_res_q.pop_front();
        e_wide = exp_wide_q.pop_front();
        e_lat  = exp_lat_q.pop_front();
        check({tag, "_lat"}, 64'(edges), 64'(e_lat));
        check({tag, "_res"}, 64'(res(u)), 64'(e_res));
        if (op != OP_MUL) check({tag, "_wide"}, wid(u), e_wide);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, "_hold_valid"}, 64'(ov(u)), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(rdy(u)), 64'd0);
            check({tag, "_hold_res"}, 64'(res(u)), 64'(e_res));
        end
        set_ready(u, 1'b1);
        @(posedge clock);
        @(negedge clock);
        set_ready(u, 1'b0);
        check({tag, "_rel_valid"}, 64'(ov(u)), 64'd0);
        check({tag, "_rel_in_ready"}, 64'(rdy(u)), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_ready(0, 1'b0);
        set_ready(1, 1'b0);

        repeat (2) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready",  64'(rdy(u)), 64'd1);
            check("rst_out_valid", 64'(ov(u)),  64'd0);
            check("rst_busy",      64'(bsy(u)), 64'd0);
            check("rst_result",    64'(res(u)), 64'd0);
            check("rst_wide",      wid(u),      64'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        // XLEN=32, BPC=1, EARLY_OUT=1
        run_op(0, "mul",    OP_MUL,    32'hFFFF_FFFF, 32'd2, 0);
        check("mul_const",  64'(res(0)), 64'hFFFF_FFFE);
        run_op(0, "mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'd2, 0);
        check("mulhu_const", 64'(res(0)), 64'h0000_0001);
        run_op(0, "mulh",   OP_MULH,   32'hFFFF_FFFF, 32'd2, 0);
        check("mulh_const", 64'(res(0)), 64'hFFFF_FFFF);
        run_op(0, "mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(0, "div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_const", 64'(res(0)), 64'h8000_0000);
        run_op(0, "rem_ovf", OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, "divu0",  OP_DIVU,   32'd7, 32'd0, 0);
        check("divu0_const", 64'(res(0)), 64'hFFFF_FFFF);
        run_op(0, "remu0",  OP_REMU,   32'd7, 32'd0, 0);
        run_op(0, "div_neg", OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_const", 64'(res(0)), 64'hFFFF_FFFD);
        run_op(0, "rem_neg", OP_REM,   32'hFFFF_FFF9, 32'd2, 0);
        check("rem_neg_const", 64'(res(0)), 64'hFFFF_FFFF);
        run_op(0, "div0s",  OP_DIV,    32'hFFFF_FFF9, 32'd0, 0);
        run_op(0, "mulz",   OP_MULH,   32'd0, 32'h1234_5678, 0);
        run_op(0, "undef",  4'hF,      32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(0, "bp",     OP_MUL,    32'h0001_0003, 32'h0000_0101, 10);

        // Flush at the 5th ITER cycle
        drive(0, 1'b1, OP_DIVU, 32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (5) begin @(posedge clock); @(negedge clock); end
        check("flush_busy_before", 64'(bsy(0)), 64'd1);
        flush1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush1 = 1'b0;
        check("flush_busy",     64'(bsy(0)), 64'd0);
        check("flush_in_ready", 64'(rdy(0)), 64'd1);
        check("flush_valid",    64'(ov(0)),  64'd0);
        seen = 0;
        repeat (40) begin @(posedge clock); @(negedge clock); if (ov(0)) seen++; end
        check("flush_no_result", 64'(seen), 64'd0);
        run_op(0, "divu_after", OP_DIVU, 32'd100, 32'd7, 0);
        check("divu_after_const", 64'(res(0)), 64'd14);
        run_op(0, "remu_after", OP_REMU, 32'd100, 32'd7, 0);
        check("remu_after_const", 64'(res(0)), 64'd2);

        // Flush wins over a same-cycle request in IDLE
        drive(0, 1'b1, OP_MUL, 32'd3, 32'd3);
        flush1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        flush1 = 1'b0;
        check("flush_idle_busy", 64'(bsy(0)), 64'd0);
        seen = 0;
        repeat (5) begin @(posedge clock); @(negedge clock); if (ov(0)) seen++; end
        check("flush_idle_no_result", 64'(seen), 64'd0);

        // Flush together with out_ready in DONE
        drive(0, 1'b1, OP_DIVU, 32'd5, 32'd0);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) begin @(posedge clock); @(negedge clock); end
        check("flush_done_valid_before", 64'(ov(0)), 64'd1);
        flush1 = 1'b1;
        set_ready(0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        flush1 = 1'b0;
        set_ready(0, 1'b0);
        check("flush_done_valid", 64'(ov(0)),  64'd0);
        check("flush_done_ready", 64'(rdy(0)), 64'd1);

        // XLEN=32, BPC=4, EARLY_OUT=0
        run_op(1, "clmul",   OP_CLMUL,  32'd3, 32'd3, 0);
        check("clmul_const", 64'(res(1)), 64'd5);
        run_op(1, "clmulh",  OP_CLMULH, 32'h8000_0000, 32'd2, 0);
        check("clmulh_const", 64'(res(1)), 64'd1);
        run_op(1, "divu0_4", OP_DIVU,   32'd7, 32'd0, 0);
        run_op(1, "div0s_4", OP_DIV,    32'hFFFF_FFF9, 32'd0, 0);
        run_op(1, "ovf_4",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, "removf_4", OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, "mulz_4",  OP_MULHSU, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(1, "undef_4", 4'hC,      32'd1, 32'd1, 0);

        // Random operands on both units
        for (int n = 0; n < 24; n++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom();
            rb  = (n % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom();
            run_op(n % 2, $sformatf("rnd%0d", n), rop, ra, rb, n % 3);
        end

        // Asynchronous reset in the middle of ITER
        drive(1, 1'b1, OP_CLMUL, 32'h1234_5678, 32'h9ABC_DEF1);
        @(posedge clock);
        @(negedge clock);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clock);
        check("areset_busy_before", 64'(bsy(1)), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_busy",      64'(bsy(1)), 64'd0);
        check("areset_in_ready",  64'(rdy(1)), 64'd1);
        check("areset_out_valid", 64'(ov(1)),  64'd0);
        check("areset_result",    64'(res(1)), 64'd0);
        check("areset_wide",      wid(1),      64'd0);
        #1 reset = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clock); @(negedge clock); if (ov(1) || bsy(1)) seen++; end
        check("areset_no_result", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
